decode_ctrl: RTL

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/decode_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_ctrl
// Brief    : Instruction decode controller. It sequences ALU, memory, halt and
//            fault handling for one 16-bit instruction at a time.
// Revision : 1.0
// ============================================================================
module decode_ctrl #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        mem_ack,
  output logic [2:0]  DEST,
  output logic [2:0]  SRC0,
  output logic [2:0]  SRC1,
  output logic [2:0]  alu_op,
  output logic        w_en,
  output logic        mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic        halted,
  output logic        fault
);

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_EXEC  = 3'd1;
  localparam logic [2:0] C_MEM   = 3'd2;
  localparam logic [2:0] C_HALT  = 3'd3;
  localparam logic [2:0] C_FAULT = 3'd4;

  localparam logic [3:0] C_OP_NOP   = 4'h0;
  localparam logic [3:0] C_OP_LOAD  = 4'h8;
  localparam logic [3:0] C_OP_STORE = 4'h9;
  localparam logic [3:0] C_OP_HALT  = 4'hF;

  // Last MEM cycle count that may still be waited on before declaring a fault.
  localparam logic [3:0] C_WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [3:0] r_wait;
  logic       r_is_store;
  logic [3:0] w_opcode;
  logic       w_capture;
  logic       w_is_alu;
  logic       w_is_memop;

  assign w_opcode   = instr[15:12];
  assign w_capture  = instr_valid && (r_state == C_IDLE);
  assign w_is_alu   = (w_opcode != C_OP_NOP) && (w_opcode[3] == 1'b0);
  assign w_is_memop = (w_opcode == C_OP_LOAD) || (w_opcode == C_OP_STORE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; mem_ack is checked before the timeout so it wins a tie.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_IDLE: begin
        if (instr_valid) begin
          if (w_opcode == C_OP_NOP) begin
            w_next_state = C_IDLE;
          end else if (w_is_alu) begin
            w_next_state = C_EXEC;
          end else if (w_is_memop) begin
            w_next_state = C_MEM;
          end else if (w_opcode == C_OP_HALT) begin
            w_next_state = C_HALT;
          end else begin
            w_next_state = C_FAULT;
          end
        end
      end
      C_EXEC: w_next_state = C_IDLE;
      C_MEM: begin
        if (mem_ack) begin
          w_next_state = C_IDLE;
        end else if (r_wait == C_WAIT_LAST) begin
          w_next_state = C_FAULT;
        end else begin
          w_next_state = C_MEM;
        end
      end
      C_HALT:  w_next_state = C_HALT;
      C_FAULT: w_next_state = C_FAULT;
      default: w_next_state = C_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state, so w_en is already one
  // cycle downstream of capture while mem follows mem_ack combinationally.
  always_comb begin
    instr_ready = 1'b0;
    w_en        = 1'b0;
    mem         = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    case (r_state)
      C_IDLE:  instr_ready = 1'b1;
      C_EXEC:  w_en        = 1'b1;
      C_MEM: begin
        mem_req = 1'b1;
        mem_we  = r_is_store;
        mem     = mem_ack && !r_is_store;
      end
      C_HALT:  halted = 1'b1;
      C_FAULT: fault  = 1'b1;
      default: instr_ready = 1'b0;
    endcase
  end

  // Captured operand fields, ALU select, access type and MEM wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DEST       <= 3'd0;
      SRC0       <= 3'd0;
      SRC1       <= 3'd0;
      alu_op     <= 3'd0;
      r_is_store <= 1'b0;
      r_wait     <= 4'd0;
    end else begin
      if (w_capture) begin
        DEST <= instr[11:9];
        SRC0 <= instr[8:6];
        SRC1 <= instr[5:3];
        if (w_is_alu) begin
          alu_op <= w_opcode[2:0];
        end
        if (w_is_memop) begin
          r_is_store <= (w_opcode == C_OP_STORE);
          r_wait     <= 4'd0;
        end
      end else if ((r_state == C_MEM) && !mem_ack) begin
        r_wait <= r_wait + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire
